fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined MIPS core.
- Holds the PC and issues a combinational-read instruction-memory request each cycle.
- Buffers fetched instructions in an FQ_DEPTH-entry queue feeding ID through a valid/ready handshake.
- Replaces the single IF/ID register with decoupled stall handling and redirect/flush from EX/MEM.

Parameters:
- XLEN, 32, width of PC, instruction and next-PC fields.
- FQ_DEPTH, 2, fetch-queue entries; must be a power of 2 and ≥ 2.
- PC_STEP, 4, sequential PC increment in bytes.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  EX/MEM branch/jump taken; flush queue and load redirect_pc.
- redirect_pc  in  XLEN  redirect target byte address.
- imem_addr  out  XLEN  current PC, driven directly from the PC register.
- imem_rdata  in  XLEN  instruction at imem_addr, valid in the same cycle.
- id_ready  in  1  ID accepts the head entry this cycle; low means hazard stall.
- id_valid  out  1  queue non-empty.
- id_inst  out  XLEN  head instruction.
- id_pc  out  XLEN  head entry's PC.
- id_pc_next  out  XLEN  head entry's PC + PC_STEP.
- fq_count  out  $clog2(FQ_DEPTH)+1  occupancy.
- fetch_fault  out  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset: PC=RESET_PC; queue empty; id_valid=0; id_inst, id_pc, id_pc_next all 0; fq_count=0; fetch_fault=0.
  - Reset has priority over every other input.
  - Reset mid-operation discards all queued entries.
- pop = id_valid & id_ready.
- push = ~redirect_valid & ~fetch_fault & (fq_count<FQ_DEPTH | pop).
  - Full queue with simultaneous pop still pushes; count is unchanged.
- On push, the entry {imem_rdata, PC, PC+PC_STEP} is written at the tail, and PC <= PC+PC_STEP.
  - Arithmetic is modulo 2^XLEN: PC 32'hFFFFFFFC wraps to 0.
- No push: PC holds.
- Redirect (redirect_valid=1):
  - Queue cleared and fq_count=0 at the edge; any pop that cycle is ignored.
  - PC <= redirect_pc with the low 2 bits cleared.
  - No push that cycle.
  - Target instruction appears at id on the edge after next (redirect edge n, fetch at n+1, id_valid=1 after n+1).
- Latency:
  - One cycle from PC presentation to id_valid.
  - With id_ready held high, steady state is one instruction per cycle with fq_count=1.
- Outputs come from registered queue storage: head read via read pointer, no combinational path from imem_rdata.
- When empty, id_inst, id_pc and id_pc_next hold 0.
- Pointers wrap modulo FQ_DEPTH.
- fq_count = count + push - pop, saturating at 0 and FQ_DEPTH.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset).
  - The queue is flushed and PC <= redirect_pc unmodified.
  - All further pushes are blocked, so id_valid stays 0.
- Not defined:
  - fetch_fault is tied 0.
  - Low bits are silently cleared as described in Behaviour.

Test Plan:
- Reset, then id_ready=1, imem returns addr+32'h1000 for 4 cycles -> imem_addr 0,4,8,12; id_inst 32'h1000,32'h1004,... with id_pc 0,4,8 and id_pc_next 4,8,12, one per cycle.
- id_ready=0 from cycle 2, FQ_DEPTH=2 -> fq_count reaches 2; PC frozen at 8 while full; release id_ready -> entries 0 and 4 pop in order, no duplicate or lost fetch.
- redirect_valid=1, redirect_pc=32'h40 with 2 entries queued -> fq_count=0 next cycle; id_valid=0 that cycle; next id_pc=32'h40.
- Redirect and pop coincide with a full queue -> flush wins; no entry survives; PC=target.
- Wrap: redirect_pc=32'hFFFFFFFC -> next fetch addresses FFFFFFFC then 0; id_pc_next=0 for the first entry.
- Misaligned redirect_pc=32'h42:
  - With FETCH_MISALIGN_CHECK_EN: fetch_fault=1, id_valid stays 0 until reset.
  - Without: next id_pc=32'h40.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: PC register, combinational imem request and an
// FQ_DEPTH-entry fetch queue feeding ID over a valid/ready handshake.
// Redirects from EX/MEM flush the queue and reload the PC.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises a sticky
// fetch_fault_o, loads the raw target and blocks all further fetches.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 2,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic [XLEN-1:0]            imem_rdata_i,
  input  logic                       id_ready_i,
  output logic                       id_valid_o,
  output logic [XLEN-1:0]            id_inst_o,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [XLEN-1:0]            id_pc_next_o,
  output logic [$clog2(FQ_DEPTH):0]  fq_count_o,
  output logic                       fetch_fault_o
);

  localparam int unsigned     PtrW    = $clog2(FQ_DEPTH);
  localparam int unsigned     CntW    = PtrW + 1;
  localparam logic [XLEN-1:0] Step    = XLEN'(PC_STEP);
  localparam logic [CntW-1:0] FullCnt = CntW'(FQ_DEPTH);
  localparam logic [XLEN-1:0] LowMask = XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fault;

  logic [XLEN-1:0] inst_mem_q   [FQ_DEPTH];
  logic [XLEN-1:0] pc_mem_q     [FQ_DEPTH];
  logic [XLEN-1:0] pc_next_mem_q[FQ_DEPTH];

  logic            valid;
  logic            pop;
  logic            push;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;

  // Misaligned targets are kept raw and poison the stage until reset.
  always_comb begin
    misaligned      = (redirect_pc_i & LowMask) != '0;
    redirect_target = misaligned ? redirect_pc_i : (redirect_pc_i & ~LowMask);
    fault_d         = fault_q | (redirect_valid_i & misaligned);
  end

  // Sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign redirect_target = redirect_pc_i & ~LowMask;
  assign fault           = 1'b0;
`endif

  // Handshake decode and next-state for PC, pointers and occupancy.
  always_comb begin
    valid    = count_q != '0;
    pop      = valid & id_ready_i;
    push     = ~redirect_valid_i & ~fault & ((count_q < FullCnt) | pop);
    pc_plus  = pc_q + Step;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid_i) begin
      // Flush wins over any pop in the same cycle.
      pc_d     = redirect_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_plus;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents are masked by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q]    <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]      <= pc_q;
      pc_next_mem_q[wr_ptr_q] <= pc_plus;
    end
  end

  // Head read from registered storage; zeros when empty.
  always_comb begin
    imem_addr_o   = pc_q;
    id_valid_o    = valid;
    id_inst_o     = '0;
    id_pc_o       = '0;
    id_pc_next_o  = '0;
    fq_count_o    = count_q;
    fetch_fault_o = fault;
    if (valid) begin
      id_inst_o    = inst_mem_q[rd_ptr_q];
      id_pc_o      = pc_mem_q[rd_ptr_q];
      id_pc_next_o = pc_next_mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with default parameters (FQ_DEPTH=2).
// Instruction memory returns address + 32'h1000.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic [1:0]  fq_count;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h1000;

  fetch_queue_stage dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .id_ready_i       (id_ready),
    .id_valid_o       (id_valid),
    .id_inst_o        (id_inst),
    .id_pc_o          (id_pc),
    .id_pc_next_o     (id_pc_next),
    .fq_count_o       (fq_count),
    .fetch_fault_o    (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [1:0] cnt);
    chk({tag, ".valid"}, {31'd0, id_valid}, 32'd1);
    chk({tag, ".inst"}, id_inst, pc + 32'h1000);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".pc_next"}, id_pc_next, pc + 32'd4);
    chk({tag, ".count"}, {30'd0, fq_count}, {30'd0, cnt});
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    step();
    do_reset();

    // Reset state.
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.valid", {31'd0, id_valid}, 32'd0);
    chk("rst.inst", id_inst, 32'h0);
    chk("rst.pc", id_pc, 32'h0);
    chk("rst.pc_next", id_pc_next, 32'h0);
    chk("rst.count", {30'd0, fq_count}, 32'd0);
    chk("rst.fault", {31'd0, fetch_fault}, 32'd0);

    // Streaming with id_ready high: one per cycle, occupancy 1.
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stream", 32'(4 * i), 2'd1);
      chk("stream.addr", imem_addr, 32'(4 * i + 4));
    end

    // Stall: fill to 2, PC frozen at 8, then drain in order.
    do_reset();
    id_ready = 1'b0;
    step();
    chk("stall.count1", {30'd0, fq_count}, 32'd1);
    step();
    chk_head("stall.full", 32'h0, 2'd2);
    chk("stall.addr", imem_addr, 32'h8);
    step();
    chk_head("stall.hold", 32'h0, 2'd2);
    chk("stall.addr_hold", imem_addr, 32'h8);
    id_ready = 1'b1;
    step();
    chk_head("drain1", 32'h4, 2'd2);
    chk("drain1.addr", imem_addr, 32'hC);
    step();
    chk_head("drain2", 32'h8, 2'd2);

    // Redirect with two entries queued.
    do_reset();
    id_ready = 1'b0;
    step();
    step();
    chk("redir.pre_count", {30'd0, fq_count}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    chk("redir.count", {30'd0, fq_count}, 32'd0);
    chk("redir.valid", {31'd0, id_valid}, 32'd0);
    chk("redir.inst", id_inst, 32'h0);
    chk("redir.addr", imem_addr, 32'h40);
    redirect_valid = 1'b0;
    step();
    chk_head("redir.first", 32'h40, 2'd1);
    chk("redir.addr2", imem_addr, 32'h44);

    // Redirect coinciding with pop on a full queue: flush wins.
    step();
    chk("rp.pre_count", {30'd0, fq_count}, 32'd2);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    chk("rp.count", {30'd0, fq_count}, 32'd0);
    chk("rp.valid", {31'd0, id_valid}, 32'd0);
    chk("rp.addr", imem_addr, 32'h80);
    redirect_valid = 1'b0;
    step();
    chk_head("rp.first", 32'h80, 2'd1);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    chk("wrap.pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc_next", id_pc_next, 32'h0);
    chk("wrap.inst", id_inst, 32'h0000_0FFC);
    chk("wrap.addr2", imem_addr, 32'h0);
    step();
    chk_head("wrap.second", 32'h0, 2'd1);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis.addr", imem_addr, 32'h42);
    chk("mis.fault", {31'd0, fetch_fault}, 32'd1);
    step();
    step();
    chk("mis.valid", {31'd0, id_valid}, 32'd0);
    chk("mis.count", {30'd0, fq_count}, 32'd0);
    chk("mis.fault_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("mis.addr_hold", imem_addr, 32'h42);
`else
    chk("mis.addr", imem_addr, 32'h40);
    chk("mis.fault", {31'd0, fetch_fault}, 32'd0);
    step();
    chk_head("mis.first", 32'h40, 2'd1);
    id_ready = 1'b0;
    step();
    chk("mis.fill", {30'd0, fq_count}, 32'd2);
`endif

    // Reset mid-operation discards everything.
    do_reset();
    chk("rst2.count", {30'd0, fq_count}, 32'd0);
    chk("rst2.valid", {31'd0, id_valid}, 32'd0);
    chk("rst2.addr", imem_addr, 32'h0);
    chk("rst2.fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst2.pc", id_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
